// File: rtl/zxdma_sequencer.sv
// ZX-bus DMA sequencer: turns synchronized ZX DMA strobes into single-byte NGS memory
// transactions at an auto-incrementing pointer, with read prefetch and /WAIT control.
module zxdma_sequencer #(
  parameter int ADDR_W   = 19,
  parameter int SYNC_LEN = 3
) (
  input  logic              cpu_clock,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_sel,
  input  logic [7:0]        cfg_din,
  output logic [7:0]        cfg_dout,
  output logic              dma_on,
  input  logic              dmaread,
  input  logic              dmawrite,
  input  logic [7:0]        dma_data_written,
  output logic [7:0]        dma_data_toberead,
  output logic              wait_ena,
  output logic              mem_req,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam int HI_W = ADDR_W - 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic                incr, valid, stale, overrun;
  logic [SYNC_LEN-1:0] rd_sync, wr_sync;
  logic                rd_end, wr_end;
  logic                ptr_wr, ctrl_wr;
  logic                ptr_inc, event_drop;
  logic                busy;
  logic [7:0]          hi_rd;

  assign ptr_wr  = cfg_wr && (cfg_sel != 2'd3);
  assign ctrl_wr = cfg_wr && (cfg_sel == 2'd3);
  assign busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync <= '0;
      wr_sync <= '0;
    end else begin
      rd_sync <= {rd_sync[SYNC_LEN-2:0], dmaread};
      wr_sync <= {wr_sync[SYNC_LEN-2:0], dmawrite};
    end
  end

  // End of a ZX cycle is the falling edge seen between the two oldest stages.
  assign rd_end = rd_sync[SYNC_LEN-1] & ~rd_sync[SYNC_LEN-2];
  assign wr_end = wr_sync[SYNC_LEN-1] & ~wr_sync[SYNC_LEN-2];

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    ptr_inc    = 1'b0;
    event_drop = 1'b0;
    case (state)
      IDLE: begin
        if (dma_on) begin
          if (wr_end) begin
            state_next = WRITE;
            event_drop = rd_end;
          end else if (rd_end) begin
            state_next = PREFETCH;
            ptr_inc    = incr;
          end else if (!valid) begin
            state_next = PREFETCH;
          end
        end
      end
      PREFETCH: begin
        event_drop = dma_on && (rd_end || wr_end);
        if (mem_ack) state_next = IDLE;
      end
      WRITE: begin
        event_drop = dma_on && (rd_end || wr_end);
        if (mem_ack) begin
          ptr_inc    = incr;
          state_next = dma_on ? PREFETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A config write to the pointer overrides the byte it targets, on top of any increment.
  always_comb begin
    ptr_next = ptr;
    if (ptr_inc) ptr_next = ptr + ADDR_W'(1);
    if (ptr_wr) begin
      case (cfg_sel)
        2'd0:    ptr_next[7:0]         = cfg_din;
        2'd1:    ptr_next[15:8]        = cfg_din;
        default: ptr_next[ADDR_W-1:16] = cfg_din[HI_W-1:0];
      endcase
    end
  end

  always_comb begin
    hi_rd            = '0;
    hi_rd[HI_W-1:0]  = ptr[ADDR_W-1:16];
    cfg_dout         = '0;
    case (cfg_sel)
      2'd0:    cfg_dout = ptr[7:0];
      2'd1:    cfg_dout = ptr[15:8];
      2'd2:    cfg_dout = hi_rd;
      default: cfg_dout = {busy, overrun, 4'b0000, incr, dma_on};
    endcase
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr               <= '0;
      dma_on            <= 1'b0;
      incr              <= 1'b0;
      overrun           <= 1'b0;
      valid             <= 1'b0;
      stale             <= 1'b0;
      mem_req           <= 1'b0;
      mem_rnw           <= 1'b1;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      dma_data_toberead <= '0;
      wait_ena          <= 1'b0;
    end else begin
      ptr <= ptr_next;

      if (ctrl_wr) begin
        dma_on  <= cfg_din[0];
        incr    <= cfg_din[1];
        overrun <= 1'b0;
      end
      if (event_drop) overrun <= 1'b1;

      mem_req  <= (state_next != IDLE);
      wait_ena <= (state_next != IDLE);

      // Request fields are latched only on entry so they stay stable until the ack.
      if (state_next == PREFETCH && state != PREFETCH) begin
        mem_rnw  <= 1'b1;
        mem_addr <= ptr_next;
        stale    <= 1'b0;
      end else if (state == PREFETCH && ptr_wr) begin
        stale    <= 1'b1;
      end

      if (state_next == WRITE && state != WRITE) begin
        mem_rnw   <= 1'b0;
        mem_addr  <= ptr;
        mem_wdata <= dma_data_written;
      end

      if (state == PREFETCH && mem_ack) dma_data_toberead <= mem_rdata;

      // A pointer moved during a prefetch leaves the fetched byte unvalidated.
      if (ptr_wr)                                             valid <= 1'b0;
      else if (state == PREFETCH && mem_ack)                  valid <= ~stale;
      else if (state == WRITE && mem_ack)                     valid <= 1'b0;
      else if (state == IDLE && dma_on && rd_end && !wr_end)  valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zxdma_sequencer.sv
// Self-checking bench for zxdma_sequencer: directed steps plus randomized ZX traffic
// compared against a pointer/memory model of the DMA behaviour.
module tb_zxdma_sequencer;
  localparam int ADDR_W   = 19;
  localparam int SYNC_LEN = 3;
  localparam int PTR_MOD  = 1 << ADDR_W;

  logic              cpu_clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [1:0]        cfg_sel = 2'd0;
  logic [7:0]        cfg_din = 8'h00;
  logic [7:0]        cfg_dout;
  logic              dma_on;
  logic              dmaread = 1'b0;
  logic              dmawrite = 1'b0;
  logic [7:0]        dma_data_written = 8'h00;
  logic [7:0]        dma_data_toberead;
  logic              wait_ena;
  logic              mem_req;
  logic              mem_rnw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ack = 1'b0;

  zxdma_sequencer #(.ADDR_W(ADDR_W), .SYNC_LEN(SYNC_LEN)) dut (
    .cpu_clock(cpu_clock), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .dma_on(dma_on), .dmaread(dmaread), .dmawrite(dmawrite),
    .dma_data_written(dma_data_written), .dma_data_toberead(dma_data_toberead),
    .wait_ena(wait_ena), .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pointer as plain integer modulo 2^ADDR_W, control bits, and a byte memory.
  int         mdl_ptr = 0;
  bit         mdl_incr = 0;
  bit         mdl_dma_on = 0;
  bit         mdl_overrun = 0;
  logic [7:0] mem_model [int];

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mem_at(input int a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  function automatic logic [7:0] exp_reg(input int sel, input bit busy);
    if (sel == 3) return {busy, mdl_overrun, 4'b0000, mdl_incr, mdl_dma_on};
    return 8'((mdl_ptr >> (8 * sel)) & 255);
  endfunction

  task automatic check_reg(input string tag, input int sel, input bit busy);
    cfg_sel = 2'(sel);
    #1;
    check(tag, 32'(cfg_dout), 32'(exp_reg(sel, busy)));
  endtask

  task automatic check_ptr_regs(input string tag);
    for (int s = 0; s < 3; s++) check_reg($sformatf("%s_sel%0d", tag, s), s, 1'b0);
  endtask

  task automatic cfg_write(input int sel, input logic [7:0] d);
    cfg_sel = 2'(sel);
    cfg_din = d;
    cfg_wr  = 1'b1;
    tick();
    cfg_wr  = 1'b0;
    if (sel == 3) begin
      mdl_dma_on  = d[0];
      mdl_incr    = d[1];
      mdl_overrun = 1'b0;
    end else begin
      mdl_ptr = ((mdl_ptr & ~(255 << (8 * sel))) | (int'(d) << (8 * sel))) % PTR_MOD;
    end
  endtask

  task automatic zx_pulse(input bit is_write, input logic [7:0] d);
    if (is_write) begin
      dma_data_written = d;
      dmawrite = 1'b1;
    end else begin
      dmaread = 1'b1;
    end
    repeat (3) tick();
    dmawrite = 1'b0;
    dmaread  = 1'b0;
  endtask

  task automatic await_req(input string tag, input bit rnw, input int addr);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req === 1'b1) seen = 1'b1;
      else tick();
    end
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_rnw"}, 32'(mem_rnw), 32'(rnw));
    check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    check({tag, "_wait"}, 32'(wait_ena), 32'd1);
  endtask

  task automatic hold(input string tag, input int cycles, input int addr);
    bit ok = 1'b1;
    repeat (cycles) begin
      tick();
      if (mem_req !== 1'b1 || 32'(mem_addr) !== addr || wait_ena !== 1'b1) ok = 1'b0;
    end
    if (cycles > 0) check({tag, "_hold"}, 32'(ok), 32'd1);
  endtask

  task automatic finish_read(input string tag, input int addr);
    logic [7:0] d;
    d = mem_at(addr);
    mem_rdata = d;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
    check({tag, "_data"}, 32'(dma_data_toberead), 32'(d));
    check({tag, "_reqlow"}, 32'(mem_req), 32'd0);
    check({tag, "_waitlow"}, 32'(wait_ena), 32'd0);
  endtask

  task automatic prefetch(input string tag, input int addr, input int delay);
    await_req(tag, 1'b1, addr);
    hold(tag, delay, addr);
    finish_read(tag, addr);
  endtask

  task automatic write_txn(input string tag, input int addr, input logic [7:0] d, input int delay);
    await_req(tag, 1'b0, addr);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
    hold(tag, delay, addr);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_model[addr] = d;
    check({tag, "_chain_req"}, 32'(mem_req), 32'd1);
    check({tag, "_chain_wait"}, 32'(wait_ena), 32'd1);
  endtask

  task automatic idle_quiet(input string tag, input int cycles);
    bit ok = 1'b1;
    repeat (cycles) begin
      tick();
      if (mem_req !== 1'b0 || wait_ena !== 1'b0) ok = 1'b0;
    end
    check({tag, "_quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         r;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    for (int s = 0; s < 4; s++) check_reg($sformatf("rst_sel%0d", s), s, 1'b0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_wait", 32'(wait_ena), 32'd0);
    check("rst_rnw", 32'(mem_rnw), 32'd1);
    check("rst_toberead", 32'(dma_data_toberead), 32'd0);
    check("rst_dma_on", 32'(dma_on), 32'd0);
    idle_quiet("rst", 6);

    // First prefetch at a programmed pointer
    mem_model[32'h01234] = 8'hA5;
    cfg_write(0, 8'h34);
    cfg_write(1, 8'h12);
    cfg_write(2, 8'h00);
    cfg_write(3, 8'h03);
    prefetch("t2", 32'h01234, 0);
    check("t2_dma_on", 32'(dma_on), 32'd1);
    check_reg("t2_ctrl", 3, 1'b0);

    // Two ZX reads with auto-increment
    mem_model[32'h01235] = 8'h11;
    mem_model[32'h01236] = 8'h22;
    for (int k = 0; k < 2; k++) begin
      zx_pulse(1'b0, 8'h00);
      mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
      prefetch($sformatf("t3_rd%0d", k), mdl_ptr, 1);
    end
    check_ptr_regs("t3_ptr");

    // ZX write at the top of memory, then wrapped prefetch
    cfg_write(3, 8'h02);
    cfg_write(0, 8'hFF);
    cfg_write(1, 8'hFF);
    cfg_write(2, 8'hFF);
    check_reg("t4_hi_masked", 2, 1'b0);
    cfg_write(3, 8'h03);
    prefetch("t4_pf", 32'h7FFFF, 0);
    zx_pulse(1'b1, 8'h5C);
    write_txn("t4_wr", 32'h7FFFF, 8'h5C, 2);
    mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
    check("t4_wrap_model", 32'(mdl_ptr), 32'd0);
    prefetch("t4_wrap", mdl_ptr, 1);
    check_ptr_regs("t4_ptr");

    // Overrun: ZX read while a prefetch is stalled
    zx_pulse(1'b0, 8'h00);
    mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
    await_req("t5", 1'b1, mdl_ptr);
    zx_pulse(1'b0, 8'h00);
    mdl_overrun = 1'b1;
    repeat (8) tick();
    check_reg("t5_ctrl_busy", 3, 1'b1);
    hold("t5", 8, mdl_ptr);
    finish_read("t5", mdl_ptr);
    idle_quiet("t5_noextra", 10);
    check_reg("t5_ctrl_ovr", 3, 1'b0);
    check_ptr_regs("t5_ptr");
    cfg_write(3, 8'h03);
    check_reg("t5_ctrl_clr", 3, 1'b0);

    // Pointer rewritten mid-prefetch: ack honoured, then re-prefetch
    zx_pulse(1'b0, 8'h00);
    r = (mdl_ptr + 1) % PTR_MOD;
    mdl_ptr = r;
    await_req("t5b", 1'b1, r);
    cfg_write(0, 8'h40);
    check("t5b_addr_stable", 32'(mem_addr), 32'(r));
    finish_read("t5b", r);
    prefetch("t5b_re", mdl_ptr, 0);

    // Randomized ZX traffic
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        zx_pulse(1'b0, 8'h00);
        if (mdl_incr) mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
        prefetch($sformatf("rnd%0d_rd", k), mdl_ptr, int'($urandom_range(0, 4)));
      end else if (r < 8) begin
        d = 8'($urandom);
        zx_pulse(1'b1, d);
        write_txn($sformatf("rnd%0d_wr", k), mdl_ptr, d, int'($urandom_range(0, 4)));
        if (mdl_incr) mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
        prefetch($sformatf("rnd%0d_pf", k), mdl_ptr, int'($urandom_range(0, 3)));
      end else if (r == 8) begin
        cfg_write(int'($urandom_range(0, 1)), 8'($urandom));
        prefetch($sformatf("rnd%0d_mv", k), mdl_ptr, int'($urandom_range(0, 2)));
      end else begin
        cfg_write(3, {6'b0, 1'($urandom), 1'b1});
        idle_quiet($sformatf("rnd%0d_ctl", k), 3);
        check_reg($sformatf("rnd%0d_ctrl", k), 3, 1'b0);
      end
    end
    check_ptr_regs("rnd_ptr");

    // dma_on cleared mid-prefetch: request completes, then everything ignored
    cfg_write(3, 8'h03);
    zx_pulse(1'b0, 8'h00);
    mdl_ptr = (mdl_ptr + 1) % PTR_MOD;
    await_req("t6", 1'b1, mdl_ptr);
    cfg_write(3, 8'h02);
    hold("t6", 10, mdl_ptr);
    finish_read("t6", mdl_ptr);
    check("t6_dma_on", 32'(dma_on), 32'd0);
    zx_pulse(1'b0, 8'h00);
    zx_pulse(1'b1, 8'h77);
    idle_quiet("t6_off", 12);
    check_reg("t6_ctrl", 3, 1'b0);
    check_ptr_regs("t6_ptr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
